// File: rtl/data_ram_responder_if.sv
// -----------------------------------------------------------------------------
// data_ram_responder_if
// Request/response bundle between the pipeline (EXE issues requests, MEM
// consumes responses) and the data-memory responder.
//   req_valid/req_ready   : request handshake (one request per cycle)
//   req_wr, req_size      : 1 = store / 0 = load; 1 = word / 0 = byte
//   req_addr, req_wdata   : byte address, unpositioned store data
//   resp_valid/resp_ready : response handshake (resp_ready = MEM allow-in)
//   resp_rdata, resp_err  : full addressed word, misaligned-word flag
// Modports: master = pipeline side, slave = responder side.
// -----------------------------------------------------------------------------
interface data_ram_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wr, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram_responder
// Data-memory responder for the load/store path. Accepts one request per
// cycle, performs byte-lane stores (SB/SW) and returns the addressed word
// (write-first) one cycle later through a single-entry response register
// that holds while the MEM stage stalls.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : data_ram_responder_if.slave (request + response handshakes)
// Parameter:
//   ADDR_WD : word-index width, array holds 2**ADDR_WD 32-bit words
// Optional feature (macro DATA_RAM_MISALIGN_CHECK_EN):
//   defined     -> word access with addr[1:0] != 0 writes nothing and
//                  responds with resp_err = 1 and the unmodified word
//   not defined -> resp_err is always 0, word accesses ignore addr[1:0]
// -----------------------------------------------------------------------------
module data_ram_responder #(
  parameter int ADDR_WD = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  data_ram_responder_if.slave  bus
);

  // Byte-enable pattern for a store of the given size at the given offset.
  function automatic logic [3:0] byte_en(input logic size, input logic [1:0] ofs);
    case (size)
      1'b0:    byte_en = 4'b0001 << ofs;
      1'b1:    byte_en = 4'hF;
      default: byte_en = 4'h0;
    endcase
  endfunction

  // Replace the enabled byte lanes of old_w with those of new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  we);
    for (int i = 0; i < 4; i++) begin
      lane_merge[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
  endfunction

  logic [31:0]        mem_q [2**ADDR_WD];
  logic [ADDR_WD-1:0] idx_s;
  logic               accept_s;
  logic [3:0]         we_s;
  logic [31:0]        lane_s;
  logic               err_s;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q,   resp_err_d;

  assign idx_s         = bus.req_addr[ADDR_WD+1:2];
  assign bus.req_ready = ~resp_valid_q | bus.resp_ready;
  assign accept_s      = bus.req_valid & bus.req_ready & ~reset;

  // Misaligned-word detection; byte accesses never fault.
`ifdef DATA_RAM_MISALIGN_CHECK_EN
  assign err_s = bus.req_size & (bus.req_addr[1:0] != 2'b00);
`else
  assign err_s = 1'b0;
`endif

  // Lane enables and lane-replicated store data; loads and faulting stores write nothing.
  always_comb begin
    we_s   = 4'h0;
    lane_s = bus.req_size ? bus.req_wdata : {4{bus.req_wdata[7:0]}};
    if (bus.req_wr && !err_s) begin
      we_s = byte_en(bus.req_size, bus.req_addr[1:0]);
    end else begin
      we_s = 4'h0;
    end
  end

  // Array write on the accept edge (contents are intentionally not reset).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept_s && we_s[i]) begin
        mem_q[idx_s][8*i +: 8] <= lane_s[8*i +: 8];
      end
    end
  end

  // Response next-state: load on accept, retire on consume, otherwise hold.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept_s) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = lane_merge(mem_q[idx_s], lane_s, we_s);
      resp_err_d   = err_s;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // Response register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
